// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and sequencer for the shared data-memory
// port. Two requesters (0 = CPU load/store, 1 = DMA/loader) share one
// synchronous memory with a fixed read latency of RD_LAT cycles. One
// transaction is in flight at a time; completion is a one-cycle ack.
module dmem_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic        mem_read,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        grant_s;
    logic        winner_s;
    logic        owner_r;
    logic        last_owner_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  be_r;
    logic [2:0]  cnt_r;
    logic [31:0] rdata_r;

    // Next-state logic and round-robin winner selection.
    always_comb begin
        state_s  = state_r;
        grant_s  = 1'b0;
        winner_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    grant_s = 1'b1;
                    // On a tie the requester that did not win last time goes first.
                    if (m0_req && m1_req) begin
                        winner_s = ~last_owner_r;
                    end else begin
                        winner_s = m1_req;
                    end
                    state_s = ST_ADDR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (we_r) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Counter reaching 1 marks the cycle the memory presents data.
                if (cnt_r <= 3'd1) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, grant bookkeeping, latched transaction, latency counter and read data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            owner_r      <= 1'b0;
            last_owner_r <= 1'b1;
            we_r         <= 1'b0;
            addr_r       <= 32'h0000_0000;
            wdata_r      <= 32'h0000_0000;
            be_r         <= 4'h0;
            cnt_r        <= 3'd0;
            rdata_r      <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            if (grant_s) begin
                owner_r      <= winner_s;
                last_owner_r <= winner_s;
                we_r         <= winner_s ? m1_we    : m0_we;
                addr_r       <= winner_s ? m1_addr  : m0_addr;
                wdata_r      <= winner_s ? m1_wdata : m0_wdata;
                be_r         <= winner_s ? m1_be    : m0_be;
            end
            if (state_r == ST_ADDR && !we_r) begin
                cnt_r <= 3'(RD_LAT);
            end else if (state_r == ST_WAIT) begin
                cnt_r <= cnt_r - 3'd1;
            end
            if (state_r == ST_WAIT && cnt_r <= 3'd1) begin
                rdata_r <= mem_rdata;
            end
        end
    end

    // Memory port is only driven during the single ADDR cycle; zero otherwise.
    assign mem_addr  = (state_r == ST_ADDR) ? addr_r  : 32'h0000_0000;
    assign mem_wdata = (state_r == ST_ADDR) ? wdata_r : 32'h0000_0000;
    assign mem_be    = (state_r == ST_ADDR) ? be_r    : 4'h0;
    assign mem_write = (state_r == ST_ADDR) &&  we_r;
    assign mem_read  = (state_r == ST_ADDR) && !we_r;

    assign m0_ack   = (state_r == ST_RESP) && !owner_r;
    assign m1_ack   = (state_r == ST_RESP) &&  owner_r;
    assign m0_rdata = rdata_r;
    assign m1_rdata = rdata_r;
    assign busy     = (state_r != ST_IDLE);
    assign owner    = owner_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (RD_LAT = 1, 2, 3) share the
// requester inputs; each has its own memory model and a transaction-timeline
// reference model.
module tb_dmem_arbiter;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_be, m1_be;

    logic [31:0] mem_rdata_i [N];
    logic        m0_ack_o [N];
    logic        m1_ack_o [N];
    logic [31:0] m0_rdata_o [N];
    logic [31:0] m1_rdata_o [N];
    logic [31:0] mem_addr_o [N];
    logic [31:0] mem_wdata_o [N];
    logic [3:0]  mem_be_o [N];
    logic        mem_write_o [N];
    logic        mem_read_o [N];
    logic        busy_o [N];
    logic        owner_o [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_arbiter #(.RD_LAT(g + 1)) u_dut (
            .clk(clk), .reset(reset),
            .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
            .m0_be(m0_be), .m0_ack(m0_ack_o[g]), .m0_rdata(m0_rdata_o[g]),
            .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
            .m1_be(m1_be), .m1_ack(m1_ack_o[g]), .m1_rdata(m1_rdata_o[g]),
            .mem_addr(mem_addr_o[g]), .mem_write(mem_write_o[g]), .mem_read(mem_read_o[g]),
            .mem_wdata(mem_wdata_o[g]), .mem_be(mem_be_o[g]), .mem_rdata(mem_rdata_i[g]),
            .busy(busy_o[g]), .owner(owner_o[g])
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: one transaction timeline per instance.
    bit          m_act [N];
    int          m_st [N];
    bit          m_who [N];
    bit          m_we [N];
    logic [31:0] m_addr [N];
    logic [31:0] m_wdata [N];
    logic [3:0]  m_be [N];
    bit          m_last [N];
    logic [31:0] m_rdq [N];
    int          due_cyc [N];
    logic [31:0] due_val [N];
    logic [31:0] rd_val;

    // Observations
    int          ack_cyc [N];
    bit          ack_who [N];
    logic [31:0] ack_dat [N];
    int          q_ack0 [$];
    bit          q_own0 [$];
    bit          q_own2 [$];

    typedef struct {
        bit          who;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdval;
        logic [31:0] exp_rdata;
        int          off1;
        int          off2;
        int          off3;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s inst%0d cyc%0d got %h expected %h", name, inst, cyc, act, exp);
        end
    endtask

    // Cycles from grant sample to the IDLE cycle after completion.
    function automatic int dur_of(input int i);
        return m_we[i] ? 3 : 4 + i;
    endfunction

    task automatic model_update();
        for (int i = 0; i < N; i++) begin
            if (!reset) begin
                m_act[i]  = 1'b0;
                m_last[i] = 1'b1;
                m_rdq[i]  = 32'h0;
            end else if (m_act[i]) begin
                if (!m_we[i] && (cyc - m_st[i]) == i + 2) m_rdq[i] = mem_rdata_i[i];
                if ((cyc - m_st[i]) == dur_of(i) - 1) m_act[i] = 1'b0;
            end else if (m0_req || m1_req) begin
                m_who[i]   = (m0_req && m1_req) ? ~m_last[i] : m1_req;
                m_last[i]  = m_who[i];
                m_act[i]   = 1'b1;
                m_st[i]    = cyc;
                m_we[i]    = m_who[i] ? m1_we    : m0_we;
                m_addr[i]  = m_who[i] ? m1_addr  : m0_addr;
                m_wdata[i] = m_who[i] ? m1_wdata : m0_wdata;
                m_be[i]    = m_who[i] ? m1_be    : m0_be;
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < N; i++) begin
            bit stb, ack;
            stb = m_act[i] && (cyc - m_st[i]) == 1;
            ack = m_act[i] && (cyc - m_st[i]) == dur_of(i) - 1;
            chk("busy", i, 32'(busy_o[i]), 32'(m_act[i]));
            if (m_act[i]) chk("owner", i, 32'(owner_o[i]), 32'(m_who[i]));
            chk("m0_ack", i, 32'(m0_ack_o[i]), 32'(ack && !m_who[i]));
            chk("m1_ack", i, 32'(m1_ack_o[i]), 32'(ack && m_who[i]));
            chk("m0_rdata", i, m0_rdata_o[i], m_rdq[i]);
            chk("m1_rdata", i, m1_rdata_o[i], m_rdq[i]);
            chk("mem_write", i, 32'(mem_write_o[i]), 32'(stb && m_we[i]));
            chk("mem_read", i, 32'(mem_read_o[i]), 32'(stb && !m_we[i]));
            chk("mem_addr", i, mem_addr_o[i], stb ? m_addr[i] : 32'h0);
            chk("mem_wdata", i, mem_wdata_o[i], stb ? m_wdata[i] : 32'h0);
            chk("mem_be", i, 32'(mem_be_o[i]), stb ? 32'(m_be[i]) : 32'h0);
            if (m0_ack_o[i] || m1_ack_o[i]) begin
                ack_cyc[i] = cyc;
                ack_who[i] = m1_ack_o[i];
                ack_dat[i] = m1_ack_o[i] ? m1_rdata_o[i] : m0_rdata_o[i];
            end
            if (i == 0 && m0_ack_o[0]) q_ack0.push_back(cyc);
            if (i == 0 && (mem_write_o[0] || mem_read_o[0])) q_own0.push_back(owner_o[0]);
            if (i == 2 && (mem_write_o[2] || mem_read_o[2])) q_own2.push_back(owner_o[2]);
            // Memory presents read data exactly RD_LAT cycles after the strobe.
            if (stb && !m_we[i]) begin
                due_cyc[i] = cyc + i + 1;
                due_val[i] = rd_val;
            end
            mem_rdata_i[i] = (due_cyc[i] == cyc) ? due_val[i] : $urandom;
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_be = 4'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_be = 4'h0;
    endtask

    task automatic set_req(input bit who, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        if (who) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
        end
    endtask

    task automatic clear_acks();
        for (int i = 0; i < N; i++) ack_cyc[i] = -1;
    endtask

    initial begin
        int t0;
        vecs[0] = '{1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0, 32'h0000_0000, 2, 2, 2};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 32'h1234_5678, 32'h1234_5678, 3, 4, 5};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 4'h0, 32'h0, 32'h1234_5678, 2, 2, 2};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'h3, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 3, 4, 5};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0204, 32'h0BAD_CAFE, 4'h5, 32'h0, 32'hA5A5_5A5A, 2, 2, 2};
        vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 32'h0000_0000, 32'h0000_0000, 3, 4, 5};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_0008, 32'h5555_AAAA, 4'hC, 32'h0, 32'h0000_0000, 2, 2, 2};

        for (int i = 0; i < N; i++) begin
            mem_rdata_i[i] = 32'h0; due_cyc[i] = -100; m_act[i] = 1'b0;
            m_st[i] = 0; m_last[i] = 1'b1; m_rdq[i] = 32'h0; m_who[i] = 1'b0; m_we[i] = 1'b0;
            m_addr[i] = 32'h0; m_wdata[i] = 32'h0; m_be[i] = 4'h0;
        end
        rd_val = 32'h0;
        clear_acks();
        idle_inputs();

        // Reset, then directed single transactions (req dropped during ADDR).
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        for (int r = 0; r < 7; r++) begin
            clear_acks();
            set_req(vecs[r].who, vecs[r].we, vecs[r].addr, vecs[r].wdata, vecs[r].be);
            rd_val = vecs[r].rdval;
            t0 = cyc;
            tick();
            idle_inputs();
            repeat (6) tick();
            for (int i = 0; i < N; i++) begin
                int off;
                off = (i == 0) ? vecs[r].off1 : (i == 1) ? vecs[r].off2 : vecs[r].off3;
                chk("vec_ack_cycle", i, 32'(ack_cyc[i]), 32'(t0 + off));
                chk("vec_ack_who", i, 32'(ack_who[i]), 32'(vecs[r].who));
                chk("vec_rdata", i, ack_dat[i], vecs[r].exp_rdata);
            end
        end

        // Contention from reset: both hold req; grants must alternate 0,1,0,1.
        reset = 1'b0;
        set_req(1'b0, 1'b1, 32'h10, 32'h1111_1111, 4'hF);
        set_req(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
        repeat (2) tick();
        q_own0.delete();
        reset = 1'b1;
        for (int k = 0; k < 40 && q_own0.size() < 4; k++) tick();
        chk("contention_grants", 0, 32'(q_own0.size()), 32'd4);
        for (int k = 0; k < 4 && k < q_own0.size(); k++)
            chk("contention_order", 0, 32'(q_own0[k]), 32'(k % 2));
        idle_inputs();
        repeat (8) tick();

        // Back-to-back reads by m0 at RD_LAT = 1: acks at T+3, T+7, T+11.
        q_ack0.delete();
        set_req(1'b0, 1'b0, 32'h300, 32'h0, 4'hF);
        t0 = cyc;
        for (int k = 0; k < 20 && q_ack0.size() < 3; k++) begin
            rd_val = $urandom;
            tick();
        end
        idle_inputs();
        chk("b2b_count", 0, 32'(q_ack0.size()), 32'd3);
        for (int k = 0; k < 3 && k < q_ack0.size(); k++)
            chk("b2b_ack_cycle", 0, 32'(q_ack0[k]), 32'(t0 + 3 + 4 * k));
        repeat (8) tick();

        // Reset during WAIT: no ack, everything quiet, then tie goes to m0.
        clear_acks();
        set_req(1'b0, 1'b0, 32'h400, 32'h0, 4'hF);
        rd_val = 32'hFEED_0001;
        tick();
        idle_inputs();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", 2, 32'(busy_o[2]), 32'd0);
        chk("rst_mem_read", 2, 32'(mem_read_o[2]), 32'd0);
        chk("rst_mem_addr", 2, mem_addr_o[2], 32'h0);
        q_own2.delete();
        set_req(1'b0, 1'b1, 32'h500, 32'h2222_2222, 4'hF);
        set_req(1'b1, 1'b1, 32'h600, 32'h3333_3333, 4'hF);
        reset = 1'b1;
        for (int k = 0; k < 10 && q_own2.size() < 1; k++) tick();
        idle_inputs();
        repeat (8) tick();
        for (int i = 0; i < N; i++)
            chk("rst_no_ack_before_release", i, 32'(ack_cyc[i] > 0 && ack_cyc[i] <= t0 + 8), 32'd0);
        chk("rst_tie_grants", 2, 32'(q_own2.size()), 32'd1);
        if (q_own2.size() > 0) chk("rst_tie_m0_first", 2, 32'(q_own2[0]), 32'd0);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 1500; k++) begin
            reset    = ($urandom_range(0, 99) != 0);
            m0_req   = ($urandom_range(0, 2) != 0);
            m1_req   = ($urandom_range(0, 2) != 0);
            m0_we    = $urandom_range(0, 1) == 1;
            m1_we    = $urandom_range(0, 1) == 1;
            m0_addr  = $urandom; m1_addr = $urandom;
            m0_wdata = $urandom; m1_wdata = $urandom;
            m0_be    = 4'($urandom); m1_be = 4'($urandom);
            rd_val   = $urandom;
            tick();
        end
        reset = 1'b1;
        idle_inputs();
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single shared data-memory port of the ARM core. Requester 0 is the CPU load/store path; requester 1 is the DMA/program-loader path. The block grants the port round-robin, holds one transaction at a time, and drives a synchronous memory with fixed read latency. It returns a one-cycle acknowledge, with read data for reads, to the owning requester.

## Interface
Parameters:
- RD_LAT, default 1: memory read latency in cycles, legal range 1..4.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk edge.
- m0_req, m1_req  in  1  transaction request; held high with fields stable until the matching ack.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  32  byte address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_be, m1_be  in  4  byte enables.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_rdata, m1_rdata  out  32  read data, valid in the ack cycle of a read.
- mem_addr  out  32  memory address.
- mem_write  out  1  write strobe.
- mem_read  out  1  read strobe.
- mem_wdata  out  32  write data to memory.
- mem_be  out  4  byte enables to memory.
- mem_rdata  in  32  memory read data.
- busy  out  1  a transaction is in progress (state is not IDLE).
- owner  out  1  index of the current owner; meaningful only while busy = 1.

## Operation
- State machine: IDLE, ADDR, WAIT, RESP.
- **IDLE**
  - If any req is high, select a winner and latch its we/addr/wdata/be into internal registers.
  - Set owner to the winner and go to ADDR.
  - With no request, stay in IDLE.
- **Arbitration**
  - A single requester wins outright.
  - If both request, the requester that is not last_owner wins.
  - last_owner updates on every grant. Its reset value is 1, so requester 0 wins the first tie.
- **ADDR** (exactly one cycle)
  - Drive mem_addr, mem_be and mem_wdata from the latched registers.
  - Assert mem_write = we and mem_read = ~we.
  - Write: go to RESP. Read: go to WAIT and load the latency counter with RD_LAT.
- **WAIT**
  - Decrement the counter each cycle.
  - In the cycle the counter equals 1, capture mem_rdata into rdata_q, then go to RESP.
  - mem_read and mem_write are 0 throughout WAIT.
- **RESP** (exactly one cycle)
  - Assert ack for the owner only.
  - m0_rdata and m1_rdata both equal rdata_q. rdata_q is unchanged by writes.
  - Go to IDLE.
- **Re-request:** a requester still holding req after its ack is treated as a new request in the following IDLE cycle and is arbitrated normally.
- **Idle outputs:** while not in ADDR, mem_addr, mem_wdata and mem_be are 0 and both strobes are 0.
- **Early req drop:** if a requester drops req before its ack, the latched transaction still completes and ack is still pulsed. The block never aborts except on reset.
- **be = 0:** the transaction is issued normally with mem_be = 0.
- **Reset** (reset = 0 at a clock edge):
  - State goes to IDLE, last_owner = 1, rdata_q = 0, counter = 0.
  - Any in-flight transaction is dropped with no ack.
  - From the next cycle: all acks 0, strobes 0, mem_* data outputs 0, busy 0, owner 0, rdata outputs 0.

## Timing
- Request sampled high in IDLE at cycle T:
  - ADDR in T+1.
  - Write: ack in T+2, IDLE in T+3.
  - Read: memory sees the strobe in T+1 and drives mem_rdata in T+1+RD_LAT. rdata_q captures it at the end of that cycle, ack is in T+2+RD_LAT, and IDLE is in T+3+RD_LAT.
- Back-to-back throughput: one write per 3 cycles; one read per RD_LAT+3 cycles.
- Worst-case wait for a requester under contention is one full transaction of the other requester plus its own. There is no starvation.
- busy = 1 from ADDR through RESP inclusive.

## Test plan
- **Single write:** m0 write, addr 0x100, wdata 0xDEADBEEF, be 0xF, at T.
  - Required: mem_write = 1 with those values in T+1 only; m0_ack in T+2 only; m1_ack stays 0.
- **Single read, RD_LAT = 2:** m1 read, addr 0x40; memory returns 0x12345678 in T+3.
  - Required: mem_read = 1 in T+1 only; m1_ack in T+4 with m1_rdata = 0x12345678.
- **Contention:** both request from reset and hold req.
  - Required: grants alternate m0, m1, m0, m1; owner toggles each transaction; the acks never coincide.
- **Early drop:** m0 drops req during ADDR.
  - Required: m0_ack is still pulsed in RESP, and the next IDLE grants nothing unless m1 is requesting.
- **Reset mid-read:** with RD_LAT = 3, drive reset = 0 during WAIT.
  - Required: no ack; next cycle busy = 0 and all mem_* outputs = 0; after release, a tie grants m0 first.
- **Back-to-back reads:** m0 holds req for 3 reads at RD_LAT = 1.
  - Required: acks at T+3, T+7 and T+11; an idle cycle precedes each ADDR.
